multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control unit for the RV64 subset datapath. It sequences fetch, decode, execute, memory and write-back. Instruction and data memories use ready/req handshakes with variable latency, a watchdog timeout, and configurable reset hold. It decodes a wider instruction set than the current state machine and traps on illegal encodings. All outputs have defined defaults in every state, so no latches are inferred.

## Interface
Parameters:
- RESET_CYCLES, 2: cycles `reset_wire` stays high after RST deasserts (≥1).
- MEM_TIMEOUT, 15: maximum wait cycles on a memory handshake before trapping. 0 disables the timeout.
- CNT_W, $clog2(max(RESET_CYCLES,MEM_TIMEOUT)+1): shared counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- instr  in  32  current IR contents.
- alu_zero  in  1  ALU result == 0, combinational, same cycle.
- alu_lt  in  1  signed A < B, combinational, same cycle.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req / dmem_we  out  1/1  data request / write enable.
- load_ir, write_pc, wr_alu_out, wr_data_mem_reg, wr_bank_reg  out  1 each  register write enables.
- reset_wire  out  1  datapath synchronous reset.
- alu_op  out  3  001 add, 010 sub, 011 and, 100 or, 101 slt.
- sel_mux_a  out  2  00 PC, 01 regA, 10 zero, 11 PC_OLD.
- sel_mux_b  out  2  00 regB, 01 const 4, 10 imm, 11 imm<<1.
- sel_mux_data  out  2  00 ALU_OUT, 01 MDR, 10 PC.
- illegal  out  1  sticky; set when the unit traps on an illegal encoding.
- fault  out  1  sticky; set when the unit traps on a memory timeout.
- state_o  out  4  current state, for debug.

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_ADDR, EXEC_BR, EXEC_LUI, EXEC_JAL, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BR_TAKE, TRAP.
- RESET: `reset_wire`=1 for RESET_CYCLES cycles, then go to FETCH.
- FETCH: `imem_req`=1. Stay while `imem_ready`=0. On ready: `load_ir`=1, `write_pc`=1, A=PC, B=4, add; go to DECODE.
- DECODE: classify `instr`.
  - Opcode 0110011 → EXEC_R.
  - Opcode 0010011 with funct3 000 → EXEC_I.
  - Opcode 0000011 with funct3 011 (ld), or 0100011 with funct3 011 (sd) → EXEC_ADDR.
  - Opcode 1100011 with funct3 000/001/100/101 (beq/bne/blt/bge) → EXEC_BR.
  - Opcode 0110111 → EXEC_LUI.
  - Opcode 1101111 → EXEC_JAL.
  - Anything else → TRAP, with `illegal` set.
- EXEC_R: A=regA, B=regB, `wr_alu_out`=1, then WB_ALU. Operation by {funct7[5],funct3}:
  - {0,000} add, {1,000} sub, {0,111} and, {0,110} or, {0,010} slt.
  - Any other combination → TRAP, with `illegal` set.
- EXEC_I / EXEC_ADDR: A=regA, B=imm, add, `wr_alu_out`=1. EXEC_I goes to WB_ALU; EXEC_ADDR goes to MEM_RD (ld) or MEM_WR (sd).
- EXEC_LUI: A=zero, B=imm, add, `wr_alu_out`=1, then WB_ALU.
- EXEC_BR: A=regA, B=regB, sub. Taken condition: beq `alu_zero`, bne !`alu_zero`, blt `alu_lt`, bge !`alu_lt`. Taken → BR_TAKE; not taken → FETCH.
- EXEC_JAL: `sel_mux_data`=10, `wr_bank_reg`=1 (rd ← PC+4), then BR_TAKE.
- BR_TAKE: A=PC_OLD, B=imm<<1, add, `write_pc`=1, then FETCH.
- MEM_RD: `dmem_req`=1. On `dmem_ready`: `wr_data_mem_reg`=1, go to WB_MEM.
- MEM_WR: `dmem_req`=1, `dmem_we`=1. On `dmem_ready`: go to FETCH.
- WB_ALU: `sel_mux_data`=00, `wr_bank_reg`=1. WB_MEM: `sel_mux_data`=01, `wr_bank_reg`=1. Both go to FETCH.
- TRAP: all enables 0, no requests. Held until RST.
- Default in every state: all enables and requests 0, `reset_wire` 0, all selects 00, `alu_op` 001.

## Timing
- Reset values: state RESET, `reset_wire`=1, counter 0, `illegal`=0, `fault`=0, every other output 0.
- Cycle counts with zero-wait memories (ready already high on the first request cycle):
  - R, addi, lui, jal, sd, taken branch: 4 cycles.
  - Not-taken branch: 3 cycles.
  - ld: 5 cycles.
- Each extra wait cycle in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- Handshake: a request stays asserted, with stable selects, until ready is sampled high. Ready outside a request is ignored.
- Timeout counter:
  - Cleared on entry to each wait state.
  - Increments each cycle the unit waits with ready low.
  - When it reaches MEM_TIMEOUT with ready still low, the next state is TRAP and `fault` is set.
  - Ready arriving in that same cycle wins; no trap occurs.
- RST asserted mid-operation, including mid-handshake: outputs drop to reset values immediately (asynchronous). The in-flight instruction is discarded.
- Counter has no wrap: it saturates because the state exits at MEM_TIMEOUT.

## Structure
- Package `ctrl_pkg`: state enum, alu_op, mux-select and opcode/funct3 localparams.
- Sub-module `ctrl_decode`: combinational classification of `instr` into instruction class, alu_op and an illegal flag. The FSM stays in `multicycle_ctrl`.

## Test plan
- RST for 1 cycle, RESET_CYCLES=2 → `reset_wire` high for 2 cycles after release, then `imem_req`=1 in FETCH.
- add x3,x1,x2 (0x002081B3) with ready held high → states FETCH, DECODE, EXEC_R, WB_ALU; `alu_op`=001; `wr_bank_reg`=1 only in cycle 4.
- ld with `dmem_ready` low for 3 cycles → `dmem_req` held 4 cycles, `wr_data_mem_reg` pulses once, WB_MEM follows, 8 cycles total.
- bne with `alu_zero`=0, then a second bne with `alu_zero`=1 → first takes BR_TAKE (`write_pc`, A=11, B=11); second returns to FETCH after 3 cycles.
- Opcode 0x7F → TRAP at cycle 3, `illegal`=1 and held. Then RST → `illegal` clears.
- MEM_TIMEOUT=15, `imem_ready` stuck low → TRAP after 16 FETCH cycles, `fault`=1. Rerun with ready rising on the 16th FETCH cycle → no trap.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle control unit
package ctrl_pkg;
   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_ADDR, S_EXEC_BR, S_EXEC_LUI,
      S_EXEC_JAL, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BR_TAKE, S_TRAP
   } state_t;
   typedef enum logic [2:0] {C_ILL, C_R, C_I, C_LD, C_SD, C_BR, C_LUI, C_JAL} cls_t;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [1:0] SA_PC    = 2'b00;
   localparam logic [1:0] SA_REGA  = 2'b01;
   localparam logic [1:0] SA_ZERO  = 2'b10;
   localparam logic [1:0] SA_PCOLD = 2'b11;
   localparam logic [1:0] SB_REGB = 2'b00;
   localparam logic [1:0] SB_FOUR = 2'b01;
   localparam logic [1:0] SB_IMM  = 2'b10;
   localparam logic [1:0] SB_IMM2 = 2'b11;
   localparam logic [1:0] SD_ALU = 2'b00;
   localparam logic [1:0] SD_MDR = 2'b01;
   localparam logic [1:0] SD_PC  = 2'b10;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: classifies instr into class, alu_op, illegal flag and branch condition
//   instr in 32 | cls out 3 (cls_t) | alu_op out 3 | illegal out 1 | br_lt/br_inv out 1
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  cls,
   output logic [2:0]  alu_op,
   output logic        illegal,
   output logic        br_lt,
   output logic        br_inv
);
   logic [6:0] op;
   logic [2:0] f3;
   logic [3:0] rsel;
   logic [2:0] r_op;
   logic       unused_bits;
   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign rsel = {instr[30], f3};
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
   // only bit 1 of funct3 separates beq/bne/blt/bge from the unused encodings
   assign cls = (op == OP_R) ? C_R :
                (op == OP_I && f3 == F3_ADD) ? C_I :
                (op == OP_LD && f3 == F3_D) ? C_LD :
                (op == OP_SD && f3 == F3_D) ? C_SD :
                (op == OP_BR && !f3[1]) ? C_BR :
                (op == OP_LUI) ? C_LUI :
                (op == OP_JAL) ? C_JAL : C_ILL;
   assign r_op = (rsel == {1'b0, F3_ADD}) ? ALU_ADD :
                 (rsel == {1'b1, F3_ADD}) ? ALU_SUB :
                 (rsel == {1'b0, F3_AND}) ? ALU_AND :
                 (rsel == {1'b0, F3_OR})  ? ALU_OR  :
                 (rsel == {1'b0, F3_SLT}) ? ALU_SLT : 3'b000;
   assign alu_op = (cls == C_R) ? r_op : (cls == C_BR) ? ALU_SUB : ALU_ADD;
   assign illegal = (cls == C_ILL) || (cls == C_R && r_op == 3'b000);
   // funct3[2] picks lt vs zero, funct3[0] inverts (bne/bge)
   assign br_lt = f3[2];
   assign br_inv = f3[0];
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/write-back sequencer with handshake timeout and traps
//   CLK, RST (async, active-high) | instr 32, alu_zero, alu_lt, imem_ready, dmem_ready in
//   imem_req, dmem_req, dmem_we, load_ir, write_pc, wr_alu_out, wr_data_mem_reg, wr_bank_reg,
//   reset_wire, alu_op 3, sel_mux_a/b/data 2, illegal, fault (sticky), state_o 4 out
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int RESET_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_W = $clog2(((RESET_CYCLES > MEM_TIMEOUT) ? RESET_CYCLES : MEM_TIMEOUT) + 1)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        alu_lt,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        load_ir,
   output logic        write_pc,
   output logic        wr_alu_out,
   output logic        wr_data_mem_reg,
   output logic        wr_bank_reg,
   output logic        reset_wire,
   output logic [2:0]  alu_op,
   output logic [1:0]  sel_mux_a,
   output logic [1:0]  sel_mux_b,
   output logic [1:0]  sel_mux_data,
   output logic        illegal,
   output logic        fault,
   output logic [3:0]  state_o
);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [2:0] cls, dec_op;
   logic dec_ill, br_lt, br_inv, taken, tmo, set_ill, set_flt;
   ctrl_decode u_dec (
      .instr(instr), .cls(cls), .alu_op(dec_op), .illegal(dec_ill), .br_lt(br_lt), .br_inv(br_inv)
   );
   assign taken = (br_lt ? alu_lt : alu_zero) ^ br_inv;
   assign tmo = (MEM_TIMEOUT != 0) && (cnt == TMO);
   // saturating so a disabled timeout never wraps
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   assign state_o = state;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= S_RESET;
         cnt <= '0;
         illegal <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         illegal <= illegal | set_ill;
         fault <= fault | set_flt;
      end
   always_comb begin
      state_n = state;
      set_ill = 1'b0;
      set_flt = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we = 1'b0;
      load_ir = 1'b0;
      write_pc = 1'b0;
      wr_alu_out = 1'b0;
      wr_data_mem_reg = 1'b0;
      wr_bank_reg = 1'b0;
      reset_wire = 1'b0;
      alu_op = ALU_ADD;
      sel_mux_a = SA_PC;
      sel_mux_b = SB_REGB;
      sel_mux_data = SD_ALU;
      case (state)
         S_RESET: begin
            reset_wire = 1'b1;
            alu_op = 3'b000;
            state_n = (cnt == RST_LAST) ? S_FETCH : S_RESET;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            sel_mux_b = SB_FOUR;
            load_ir = imem_ready;
            write_pc = imem_ready;
            state_n = imem_ready ? S_DECODE : tmo ? S_TRAP : S_FETCH;
            set_flt = !imem_ready && tmo;
         end
         S_DECODE: begin
            state_n = (cls == C_R) ? S_EXEC_R :
                      (cls == C_I) ? S_EXEC_I :
                      (cls == C_LD || cls == C_SD) ? S_EXEC_ADDR :
                      (cls == C_BR) ? S_EXEC_BR :
                      (cls == C_LUI) ? S_EXEC_LUI :
                      (cls == C_JAL) ? S_EXEC_JAL : S_TRAP;
            set_ill = (cls == C_ILL);
         end
         S_EXEC_R: begin
            sel_mux_a = SA_REGA;
            alu_op = dec_op;
            wr_alu_out = !dec_ill;
            state_n = dec_ill ? S_TRAP : S_WB_ALU;
            set_ill = dec_ill;
         end
         S_EXEC_I, S_EXEC_ADDR: begin
            sel_mux_a = SA_REGA;
            sel_mux_b = SB_IMM;
            wr_alu_out = 1'b1;
            state_n = (state == S_EXEC_I) ? S_WB_ALU : (cls == C_LD) ? S_MEM_RD : S_MEM_WR;
         end
         S_EXEC_LUI: begin
            sel_mux_a = SA_ZERO;
            sel_mux_b = SB_IMM;
            wr_alu_out = 1'b1;
            state_n = S_WB_ALU;
         end
         S_EXEC_BR: begin
            sel_mux_a = SA_REGA;
            alu_op = ALU_SUB;
            state_n = taken ? S_BR_TAKE : S_FETCH;
         end
         S_EXEC_JAL: begin
            sel_mux_data = SD_PC;
            wr_bank_reg = 1'b1;
            state_n = S_BR_TAKE;
         end
         S_BR_TAKE: begin
            sel_mux_a = SA_PCOLD;
            sel_mux_b = SB_IMM2;
            write_pc = 1'b1;
            state_n = S_FETCH;
         end
         S_MEM_RD: begin
            dmem_req = 1'b1;
            wr_data_mem_reg = dmem_ready;
            state_n = dmem_ready ? S_WB_MEM : tmo ? S_TRAP : S_MEM_RD;
            set_flt = !dmem_ready && tmo;
         end
         S_MEM_WR: begin
            dmem_req = 1'b1;
            dmem_we = 1'b1;
            state_n = dmem_ready ? S_FETCH : tmo ? S_TRAP : S_MEM_WR;
            set_flt = !dmem_ready && tmo;
         end
         S_WB_ALU: begin
            wr_bank_reg = 1'b1;
            state_n = S_FETCH;
         end
         S_WB_MEM: begin
            sel_mux_data = SD_MDR;
            wr_bank_reg = 1'b1;
            state_n = S_FETCH;
         end
         default: state_n = S_TRAP;
      endcase
      // staying in RESET or a wait state counts; any transition restarts from zero
      cnt_n = (state_n == state && state != S_TRAP) ? cnt_inc : '0;
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
   logic CLK = 1'b0, RST = 1'b1;
   logic [31:0] instr = '0;
   logic alu_zero = 1'b0, alu_lt = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic imem_req, dmem_req, dmem_we, load_ir, write_pc, wr_alu_out, wr_data_mem_reg, wr_bank_reg;
   logic reset_wire, illegal, fault;
   logic [2:0] alu_op;
   logic [1:0] sel_mux_a, sel_mux_b, sel_mux_data;
   logic [3:0] state_o;
   int n_tests = 0, n_fail = 0;
   localparam logic [31:0] I_ADD = 32'h002081B3, I_LD = 32'h0000B283, I_BNE = 32'h00209063;
   multicycle_ctrl dut (
      .CLK(CLK), .RST(RST), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .load_ir(load_ir), .write_pc(write_pc), .wr_alu_out(wr_alu_out),
      .wr_data_mem_reg(wr_data_mem_reg), .wr_bank_reg(wr_bank_reg), .reset_wire(reset_wire),
      .alu_op(alu_op), .sel_mux_a(sel_mux_a), .sel_mux_b(sel_mux_b), .sel_mux_data(sel_mux_data),
      .illegal(illegal), .fault(fault), .state_o(state_o)
   );
   always #5 CLK = ~CLK;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic cyc;
      @(posedge CLK);
      #2;
   endtask
   task automatic do_reset;
      RST = 1'b1; instr = '0; alu_zero = 0; alu_lt = 0; imem_ready = 0; dmem_ready = 0;
      @(posedge CLK);
      #2;
      RST = 1'b0;
      cyc();
      cyc();
   endtask
   task automatic test_reset;
      RST = 1'b1; imem_ready = 1'b0;
      #1;
      n_tests++;
      if (state_o !== 4'd0 || reset_wire !== 1'b1 || illegal !== 1'b0 || fault !== 1'b0 ||
          imem_req !== 1'b0 || dmem_req !== 1'b0 || write_pc !== 1'b0 || wr_bank_reg !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: state=%0d rw=%b ill=%b flt=%b ireq=%b dreq=%b, want 0/1/0/0/0/0",
                  state_o, reset_wire, illegal, fault, imem_req, dmem_req);
      end
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      n_tests++;
      if (state_o !== 4'd0 || reset_wire !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold1: state=%0d rw=%b, want 0/1", state_o, reset_wire);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd0 || reset_wire !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold2: state=%0d rw=%b, want 0/1", state_o, reset_wire);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd1 || imem_req !== 1'b1 || reset_wire !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_to_fetch: state=%0d ireq=%b rw=%b, want 1/1/0", state_o, imem_req, reset_wire);
      end
   endtask
   task automatic test_add;
      do_reset();
      instr = I_ADD; imem_ready = 1'b1;
      #1;
      n_tests++;
      if (state_o !== 4'd1 || load_ir !== 1'b1 || write_pc !== 1'b1 || sel_mux_b !== 2'b01 ||
          alu_op !== 3'b001 || wr_bank_reg !== 1'b0) begin
         n_fail++;
         $display("FAIL add_fetch: state=%0d ld_ir=%b wpc=%b selb=%b op=%b wb=%b, want 1/1/1/01/001/0",
                  state_o, load_ir, write_pc, sel_mux_b, alu_op, wr_bank_reg);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd2 || wr_bank_reg !== 1'b0) begin
         n_fail++;
         $display("FAIL add_decode: state=%0d wb=%b, want 2/0", state_o, wr_bank_reg);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd3 || alu_op !== 3'b001 || wr_alu_out !== 1'b1 || sel_mux_a !== 2'b01 ||
          sel_mux_b !== 2'b00 || wr_bank_reg !== 1'b0) begin
         n_fail++;
         $display("FAIL add_exec: state=%0d op=%b wao=%b a=%b b=%b wb=%b, want 3/001/1/01/00/0",
                  state_o, alu_op, wr_alu_out, sel_mux_a, sel_mux_b, wr_bank_reg);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd11 || wr_bank_reg !== 1'b1 || sel_mux_data !== 2'b00) begin
         n_fail++;
         $display("FAIL add_wb: state=%0d wb=%b sd=%b, want 11/1/00", state_o, wr_bank_reg, sel_mux_data);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd1 || wr_bank_reg !== 1'b0) begin
         n_fail++;
         $display("FAIL add_done: state=%0d wb=%b, want 1/0", state_o, wr_bank_reg);
      end
   endtask
   task automatic test_ld_wait;
      int reqs, wdm;
      logic [3:0] st7;
      reqs = 0; wdm = 0; st7 = '0;
      do_reset();
      instr = I_LD; imem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dmem_ready = (i == 6);
         #1;
         reqs += int'(dmem_req);
         wdm += int'(wr_data_mem_reg);
         if (i == 7) st7 = state_o;
         cyc();
      end
      dmem_ready = 1'b0;
      n_tests++;
      if (reqs != 4) begin
         n_fail++;
         $display("FAIL ld_req_cycles: got %0d, want 4", reqs);
      end
      n_tests++;
      if (wdm != 1) begin
         n_fail++;
         $display("FAIL ld_mdr_pulses: got %0d, want 1", wdm);
      end
      n_tests++;
      if (st7 !== 4'd12) begin
         n_fail++;
         $display("FAIL ld_wb_mem: state=%0d, want 12", st7);
      end
      n_tests++;
      if (state_o !== 4'd1) begin
         n_fail++;
         $display("FAIL ld_total_8: state=%0d, want 1", state_o);
      end
   endtask
   task automatic test_branch;
      do_reset();
      instr = I_BNE; imem_ready = 1'b1; alu_zero = 1'b0;
      cyc();
      cyc();
      n_tests++;
      if (state_o !== 4'd6 || alu_op !== 3'b010 || sel_mux_a !== 2'b01 || sel_mux_b !== 2'b00) begin
         n_fail++;
         $display("FAIL bne_exec: state=%0d op=%b a=%b b=%b, want 6/010/01/00", state_o, alu_op, sel_mux_a, sel_mux_b);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd13 || write_pc !== 1'b1 || sel_mux_a !== 2'b11 || sel_mux_b !== 2'b11 || alu_op !== 3'b001) begin
         n_fail++;
         $display("FAIL bne_take: state=%0d wpc=%b a=%b b=%b op=%b, want 13/1/11/11/001",
                  state_o, write_pc, sel_mux_a, sel_mux_b, alu_op);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd1) begin
         n_fail++;
         $display("FAIL bne_take_done: state=%0d, want 1", state_o);
      end
      alu_zero = 1'b1;
      cyc();
      cyc();
      cyc();
      n_tests++;
      if (state_o !== 4'd1 || write_pc !== 1'b1) begin
         n_fail++;
         $display("FAIL bne_not_taken_3cyc: state=%0d wpc=%b, want 1/1", state_o, write_pc);
      end
   endtask
   task automatic test_branch_conds;
      logic [31:0] bi [5] = '{32'h00208063, 32'h00208063, 32'h0020C063, 32'h0020D063, 32'h0020D063};
      logic bz [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic bl [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic bt [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      imem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         instr = bi[k]; alu_zero = bz[k]; alu_lt = bl[k];
         cyc();
         cyc();
         cyc();
         n_tests++;
         if (state_o !== (bt[k] ? 4'd13 : 4'd1)) begin
            n_fail++;
            $display("FAIL branch_cond[%0d]: state=%0d, want %0d", k, state_o, bt[k] ? 13 : 1);
         end
         if (bt[k]) cyc();
      end
      alu_zero = 1'b0; alu_lt = 1'b0;
   endtask
   task automatic test_classes;
      logic [31:0] ci [8] = '{32'h00108093, 32'h123450B7, 32'h008000EF, 32'h0020B023,
                             32'h402081B3, 32'h0020A1B3, 32'h0020E1B3, 32'h0020F1B3};
      logic [3:0] s3 [8] = '{4'd4, 4'd7, 4'd8, 4'd5, 4'd3, 4'd3, 4'd3, 4'd3};
      logic [3:0] s4 [8] = '{4'd11, 4'd11, 4'd13, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11};
      logic [2:0] op3 [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b101, 3'b100, 3'b011};
      logic [1:0] a3 [8] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      do_reset();
      imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         instr = ci[k];
         cyc();
         cyc();
         n_tests++;
         if (state_o !== s3[k] || alu_op !== op3[k] || sel_mux_a !== a3[k]) begin
            n_fail++;
            $display("FAIL class_exec[%0d]: state=%0d op=%b a=%b, want %0d/%b/%b",
                     k, state_o, alu_op, sel_mux_a, s3[k], op3[k], a3[k]);
         end
         cyc();
         n_tests++;
         if (state_o !== s4[k]) begin
            n_fail++;
            $display("FAIL class_step4[%0d]: state=%0d, want %0d", k, state_o, s4[k]);
         end
         cyc();
         n_tests++;
         if (state_o !== 4'd1) begin
            n_fail++;
            $display("FAIL class_4cyc[%0d]: state=%0d, want 1", k, state_o);
         end
      end
      dmem_ready = 1'b0;
   endtask
   task automatic test_jal_sd_outputs;
      do_reset();
      imem_ready = 1'b1; dmem_ready = 1'b0; instr = 32'h008000EF;
      cyc();
      cyc();
      n_tests++;
      if (sel_mux_data !== 2'b10 || wr_bank_reg !== 1'b1) begin
         n_fail++;
         $display("FAIL jal_link: sd=%b wb=%b, want 10/1", sel_mux_data, wr_bank_reg);
      end
      cyc();
      cyc();
      instr = 32'h0020B023;
      cyc();
      cyc();
      cyc();
      n_tests++;
      if (state_o !== 4'd10 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL sd_req: state=%0d dreq=%b we=%b, want 10/1/1", state_o, dmem_req, dmem_we);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd10 || dmem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL sd_hold: state=%0d dreq=%b, want 10/1", state_o, dmem_req);
      end
   endtask
   task automatic test_illegal;
      do_reset();
      instr = 32'h0000007F; imem_ready = 1'b1;
      cyc();
      n_tests++;
      if (state_o !== 4'd2 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_decode: state=%0d ill=%b, want 2/0", state_o, illegal);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd14 || illegal !== 1'b1 || imem_req !== 1'b0 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_trap: state=%0d ill=%b ireq=%b flt=%b, want 14/1/0/0", state_o, illegal, imem_req, fault);
      end
      cyc();
      cyc();
      n_tests++;
      if (state_o !== 4'd14 || illegal !== 1'b1 || write_pc !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_hold: state=%0d ill=%b wpc=%b, want 14/1/0", state_o, illegal, write_pc);
      end
      RST = 1'b1;
      #1;
      n_tests++;
      if (illegal !== 1'b0 || state_o !== 4'd0) begin
         n_fail++;
         $display("FAIL ill_clear: ill=%b state=%0d, want 0/0", illegal, state_o);
      end
      do_reset();
      instr = 32'h4020F1B3; imem_ready = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if (state_o !== 4'd3 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL r_ill_exec: state=%0d ill=%b, want 3/0", state_o, illegal);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd14 || illegal !== 1'b1) begin
         n_fail++;
         $display("FAIL r_ill_trap: state=%0d ill=%b, want 14/1", state_o, illegal);
      end
   endtask
   task automatic test_timeout;
      do_reset();
      instr = 32'h00108093; imem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_tests++;
         if (state_o !== 4'd1 || fault !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_wait[%0d]: state=%0d flt=%b ireq=%b, want 1/0/1", i, state_o, fault, imem_req);
         end
         cyc();
      end
      n_tests++;
      if (state_o !== 4'd14 || fault !== 1'b1 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_trap: state=%0d flt=%b ill=%b, want 14/1/0", state_o, fault, illegal);
      end
      do_reset();
      imem_ready = 1'b0;
      for (int i = 0; i < 15; i++) cyc();
      imem_ready = 1'b1;
      #1;
      n_tests++;
      if (state_o !== 4'd1 || load_ir !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_late_ready: state=%0d ld_ir=%b, want 1/1", state_o, load_ir);
      end
      cyc();
      n_tests++;
      if (state_o !== 4'd2 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_no_trap: state=%0d flt=%b, want 2/0", state_o, fault);
      end
   endtask
   task automatic test_rst_mid;
      do_reset();
      instr = I_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
      cyc();
      cyc();
      cyc();
      n_tests++;
      if (state_o !== 4'd9 || dmem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: state=%0d dreq=%b, want 9/1", state_o, dmem_req);
      end
      RST = 1'b1;
      #1;
      n_tests++;
      if (state_o !== 4'd0 || dmem_req !== 1'b0 || reset_wire !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rst: state=%0d dreq=%b rw=%b, want 0/0/1", state_o, dmem_req, reset_wire);
      end
   endtask
   initial begin
      test_reset();
      test_add();
      test_ld_wait();
      test_branch();
      test_branch_conds();
      test_classes();
      test_jal_sd_outputs();
      test_illegal();
      test_timeout();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
